// File: rtl/mux2.sv
// Two-input mux with a combinational output, a registered copy of that output,
// and a saturating count of select-line transitions.
module mux2 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    input  logic             s,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] f_q,
    output logic [CNT_W-1:0] sel_changes
);

    if (WIDTH < 1) begin : g_bad_width
        $error("mux2: WIDTH must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("mux2: CNT_W must be at least 1");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             s_prev_q;
    logic             s_prev_d;
    logic [WIDTH-1:0] f_q_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The ternary merges x1/x2 bitwise when s is unknown, so agreeing bits stay known.
    assign f = s ? x2 : x1;

    always_comb begin
        s_prev_d = s;
        f_q_d    = f;
        cnt_d    = cnt_q;
        if (rst) begin
            f_q_d = '0;
            cnt_d = '0;
        end else if ((s != s_prev_q) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // s_prev is loaded even during reset so the first post-reset edge never counts.
    always_ff @(posedge clk) begin
        s_prev_q <= s_prev_d;
        f_q      <= f_q_d;
        cnt_q    <= cnt_d;
    end

    assign sel_changes = cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (f == (s ? x2 : x1));
        end
    end

endmodule

// File: tb/tb_mux2.sv
// Scoreboard bench for mux2: a 1-bit/8-bit-counter instance and an
// 8-bit/2-bit-counter instance share clock, reset and select.
module tb_mux2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       s   = 1'b0;
    logic       x1a = 1'b0;
    logic       x2a = 1'b0;
    logic [7:0] x1b = 8'h00;
    logic [7:0] x2b = 8'h00;
    logic       fa, fqa;
    logic [7:0] fb, fqb;
    logic [7:0] cnta;
    logic [1:0] cntb;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] fqa;
        logic [7:0] fqb;
        logic [7:0] cnta;
        logic [7:0] cntb;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    logic m_sprev;
    int   m_cnta;
    int   m_cntb;

    always #5 clk = ~clk;

    mux2 #(.WIDTH(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .x1(x1a), .x2(x2a), .s(s),
        .f(fa), .f_q(fqa), .sel_changes(cnta)
    );

    mux2 #(.WIDTH(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .x1(x1b), .x2(x2b), .s(s),
        .f(fb), .f_q(fqb), .sel_changes(cntb)
    );

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Checks f now, queues the expected registered state, then checks it after the edge.
    task automatic cycle(input logic r, input string tag);
        exp_t e;
        exp_t got;
        rst = r;
        #1;
        chk_val({tag, ".fa"}, {31'd0, fa}, {31'd0, (s ? x2a : x1a)});
        chk_val({tag, ".fb"}, {24'd0, fb}, {24'd0, (s ? x2b : x1b)});
        if (r) begin
            e.fqa = 8'd0; e.fqb = 8'd0;
            m_cnta = 0;   m_cntb = 0;
        end else begin
            e.fqa = {7'd0, (s ? x2a : x1a)};
            e.fqb = s ? x2b : x1b;
            if (s != m_sprev) begin
                if (m_cnta < 255) m_cnta++;
                if (m_cntb < 3)   m_cntb++;
            end
        end
        m_sprev = s;
        e.cnta = m_cnta[7:0];
        e.cntb = m_cntb[7:0];
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk_val({tag, ".fqa"},  {31'd0, fqa},  {24'd0, got.fqa});
        chk_val({tag, ".fqb"},  {24'd0, fqb},  {24'd0, got.fqb});
        chk_val({tag, ".cnta"}, {24'd0, cnta}, {24'd0, got.cnta});
        chk_val({tag, ".cntb"}, {30'd0, cntb}, {24'd0, got.cntb});
        $display("cycle %s rst=%0b s=%0b fqa=%0h fqb=%0h cnta=%0d cntb=%0d",
                 tag, r, s, fqa, fqb, cnta, cntb);
        @(negedge clk);
    endtask

    initial begin
        m_sprev = 1'b0;
        m_cnta  = 0;
        m_cntb  = 0;
        @(negedge clk);

        // Reset state
        cycle(1'b1, "reset");
        cycle(1'b0, "idle");

        // x1=0, x2=1, s=1 -> f=1 immediately, f_q=1 after the edge
        x1a = 1'b0; x2a = 1'b1; s = 1'b1;
        #1 chk_val("imm_sel_x2", {31'd0, fa}, 32'd1);
        cycle(1'b0, "sel_x2");

        // x1=1, x2=0, s=1 -> f=0; x2 rising shows on f without a clock
        x1a = 1'b1; x2a = 1'b0;
        #1 chk_val("imm_x2_lo", {31'd0, fa}, 32'd0);
        x2a = 1'b1;
        #0 chk_val("imm_x2_hi", {31'd0, fa}, 32'd1);
        cycle(1'b0, "x2_track");

        // s=0, x1=0, x2=1 -> f=0; x1 rising -> f=1; s 1->0 counted
        s = 1'b0; x1a = 1'b0; x2a = 1'b1;
        #1 chk_val("imm_sel_x1", {31'd0, fa}, 32'd0);
        x1a = 1'b1;
        #0 chk_val("imm_x1_hi", {31'd0, fa}, 32'd1);
        cycle(1'b0, "x1_track");

        // Reset with s toggling; f keeps tracking during reset
        s = 1'b1;
        cycle(1'b1, "rst_tog1");
        s = 1'b0;
        cycle(1'b1, "rst_tog2");
        cycle(1'b0, "post_rst");

        // Saturation of the 2-bit counter while the wide mux alternates A5/3C
        x1b = 8'hA5; x2b = 8'h3C;
        for (int i = 0; i < 6; i++) begin
            s = ~s;
            cycle(1'b0, $sformatf("sat%0d", i));
        end

        // Random traffic with occasional reset
        for (int i = 0; i < 40; i++) begin
            s   = 1'($urandom_range(0, 1));
            x1a = 1'($urandom_range(0, 1));
            x2a = 1'($urandom_range(0, 1));
            x1b = 8'($urandom_range(0, 255));
            x2b = 8'($urandom_range(0, 255));
            cycle(($urandom_range(0, 9) == 0), $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mux2.md
MUX2 -- requirements
Module: mux2

Interface
REQ-001 Parameter WIDTH, default 1, data-path width of x1, x2, f, f_q.
REQ-002 Parameter CNT_W, default 8, width of sel_changes counter.
REQ-003 One clock; reset is synchronous and active-high; ports named clk and rst.
REQ-004 clk  input  1  rising-edge clock for all registered state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 x1  input  WIDTH  data input selected when s=0.
REQ-007 x2  input  WIDTH  data input selected when s=1.
REQ-008 s  input  1  select.
REQ-009 f  output  WIDTH  combinational mux output.
REQ-010 f_q  output  WIDTH  registered copy of f.
REQ-011 sel_changes  output  CNT_W  saturating count of select transitions.

Function
REQ-012 f SHALL equal x1 when s=0 and x2 when s=1, purely combinational, zero cycles latency, independent of clk and rst.
REQ-013 f SHALL update in the same simulation time step as any change on x1, x2 or s; no clock required.
REQ-014 s=X/Z: f SHALL be X, except bitwise where x1 and x2 agree.
REQ-015 f_q SHALL load f on every rising clk edge with rst=0; latency exactly 1 cycle.
REQ-016 Internal register s_prev SHALL sample s each rising edge.
REQ-017 sel_changes SHALL increment by 1 on each rising edge where s differs from s_prev and rst=0.
REQ-018 sel_changes SHALL saturate at 2^CNT_W-1; no wrap-around.
REQ-019 Simultaneous change of s and data: f_q captures the value of f for the new s.
REQ-020 No handshake; all inputs valid every cycle.

Reset
REQ-021 rst=1 at a rising edge: f_q SHALL become 0, sel_changes 0, s_prev takes current s (no count on the first post-reset edge).
REQ-022 rst SHALL NOT affect f.
REQ-023 Reset asserted mid-operation SHALL take effect on the next rising edge, overriding increment and f_q load.
REQ-024 Outputs f_q and sel_changes are undefined before the first reset edge.

Structure
REQ-025 No shared package; no typedefs; only the two parameters.
REQ-026 Single flat module; no sub-module is natural; the combinational mux and registers live in mux2.
REQ-027 Implementation target 120-400 lines including parameter checks (WIDTH>=1, CNT_W>=1) and a self-check assertion block (f == (s ? x2 : x1)).

Verification
REQ-028 x1=0, x2=1, s=1 -> f=1 immediately; after next edge f_q=1.
REQ-029 x1=1, x2=0, s=1 -> f=0; then x2=1 -> f=1 in same time step.
REQ-030 s=0, x1=0, x2=1 -> f=0; then x1=1 -> f=1; sel_changes increments by 1 for the s 1->0 transition.
REQ-031 rst=1 for one edge with s toggling -> f_q=0, sel_changes=0, f still tracks inputs during reset.
REQ-032 CNT_W=2, toggle s every cycle for 5 cycles -> sel_changes counts 1,2,3,3,3 (saturates).
REQ-033 WIDTH=8, x1=8'hA5, x2=8'h3C, s toggles -> f alternates A5/3C; f_q follows one cycle later.
